param_issue_queue: RTL

//  Parametrised, age-ordered, collapsing issue queue. Successor of the fixed 2-source integer issue queue.

---
 rtl/param_issue_queue.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/param_issue_queue.sv
// Age-ordered collapsing issue queue: slot 0 is oldest, N_BCAST wakeup/capture channels,
// registered issue stage with back-pressure, ROB-age-selective flush.
module param_issue_queue #(
    parameter int N_ENTRIES     = 8,
    parameter int N_BCAST       = 2,
    parameter int ROB_ID_WIDTH  = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int PAYLOAD_WIDTH = 64
) (
    input  logic                              clk,
    input  logic                              rst_aL,
    output logic                              enq_ready,
    input  logic                              enq_valid,
    input  logic [ROB_ID_WIDTH-1:0]           enq_rob_id,
    input  logic [1:0]                        enq_src_valid,
    input  logic [1:0]                        enq_src_ready,
    input  logic [2*ROB_ID_WIDTH-1:0]         enq_src_rob_id,
    input  logic [2*DATA_WIDTH-1:0]           enq_src_data,
    input  logic [PAYLOAD_WIDTH-1:0]          enq_payload,
    input  logic [N_BCAST-1:0]                bcast_valid,
    input  logic [N_BCAST*ROB_ID_WIDTH-1:0]   bcast_rob_id,
    input  logic [N_BCAST*DATA_WIDTH-1:0]     bcast_data,
    input  logic                              issue_ready,
    output logic                              issue_valid,
    output logic [ROB_ID_WIDTH-1:0]           issue_rob_id,
    output logic [2*DATA_WIDTH-1:0]           issue_src_data,
    output logic [PAYLOAD_WIDTH-1:0]          issue_payload,
    input  logic                              flush_valid,
    input  logic [ROB_ID_WIDTH-1:0]           flush_rob_id,
    input  logic [ROB_ID_WIDTH-1:0]           rob_head_id,
    output logic [$clog2(N_ENTRIES):0]        occupancy
);
    localparam int RIW   = ROB_ID_WIDTH;
    localparam int DW    = DATA_WIDTH;
    localparam int PW    = PAYLOAD_WIDTH;
    localparam int OCC_W = $clog2(N_ENTRIES) + 1;
    localparam int IDX_W = $clog2(N_ENTRIES);

    typedef struct packed {
        logic          rdy;
        logic [DW-1:0] data;
        logic          multi;
    } cap_t;

    logic [RIW-1:0]   r_rob   [N_ENTRIES];
    logic [1:0]       r_sv    [N_ENTRIES];
    logic [1:0]       r_sr    [N_ENTRIES];
    logic [RIW-1:0]   r_stag  [N_ENTRIES][2];
    logic [DW-1:0]    r_sdata [N_ENTRIES][2];
    logic [PW-1:0]    r_pay   [N_ENTRIES];
    logic [OCC_W-1:0] r_occ;

    logic             r_iss_valid;
    logic [RIW-1:0]   r_iss_rob;
    logic [2*DW-1:0]  r_iss_data;
    logic [PW-1:0]    r_iss_pay;

    logic [1:0]       w_sr_eff [N_ENTRIES];
    logic [DW-1:0]    w_sd_eff [N_ENTRIES][2];
    logic [1:0]       w_esr;
    logic [DW-1:0]    w_esd [2];
    logic [N_ENTRIES-1:0] w_valid, w_rdy, w_shift;
    logic             w_multi, w_any, w_load, w_deq, w_enq;
    logic [IDX_W-1:0] w_sel;
    logic [OCC_W-1:0] w_keep, w_enq_slot;
    logic [RIW-1:0]   w_flush_age;
    cap_t             w_cap;

    // Lowest channel wins; a second hit only raises the multi flag.
    function automatic cap_t f_capture(input logic sv, input logic sr,
                                       input logic [RIW-1:0] tag, input logic [DW-1:0] d);
        cap_t r;
        logic hit;
        r     = '{rdy: sr, data: d, multi: 1'b0};
        hit   = 1'b0;
        for (int unsigned c = 0; c < N_BCAST; c++) begin
            if (sv && !sr && bcast_valid[c] && bcast_rob_id[c*RIW +: RIW] == tag) begin
                if (hit) begin
                    r.multi = 1'b1;
                end else begin
                    r.rdy  = 1'b1;
                    r.data = bcast_data[c*DW +: DW];
                end
                hit = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [RIW-1:0] f_age(input logic [RIW-1:0] t);
        return t - rob_head_id;
    endfunction

    assign enq_ready   = r_occ < OCC_W'(N_ENTRIES);
    assign w_load      = !r_iss_valid || issue_ready;
    assign w_deq       = w_load && w_any && !flush_valid;
    assign w_enq       = enq_valid && enq_ready && !flush_valid;
    assign w_enq_slot  = r_occ - OCC_W'(w_deq);
    assign w_flush_age = f_age(flush_rob_id);

    always_comb begin
        w_multi = 1'b0;
        w_cap   = '0;
        w_esr   = '0;
        for (int unsigned i = 0; i < N_ENTRIES; i++) begin
            w_valid[i]  = OCC_W'(i) < r_occ;
            w_sr_eff[i] = '0;
            for (int unsigned s = 0; s < 2; s++) begin
                w_cap          = f_capture(r_sv[i][s], r_sr[i][s], r_stag[i][s], r_sdata[i][s]);
                w_sr_eff[i][s] = w_cap.rdy;
                w_sd_eff[i][s] = w_cap.data;
                if (w_valid[i] && w_cap.multi) w_multi = 1'b1;
            end
        end
        for (int unsigned s = 0; s < 2; s++) begin
            w_cap    = f_capture(enq_src_valid[s], enq_src_ready[s],
                                 enq_src_rob_id[s*RIW +: RIW], enq_src_data[s*DW +: DW]);
            w_esr[s] = w_cap.rdy;
            w_esd[s] = w_cap.data;
            if (w_enq && w_cap.multi) w_multi = 1'b1;
        end
    end

    always_comb begin
        w_any  = 1'b0;
        w_sel  = '0;
        w_keep = '0;
        for (int unsigned i = 0; i < N_ENTRIES; i++) begin
            w_rdy[i] = w_valid[i] && (!r_sv[i][0] || w_sr_eff[i][0])
                                  && (!r_sv[i][1] || w_sr_eff[i][1]);
            if (w_rdy[i] && !w_any) begin
                w_any = 1'b1;
                w_sel = IDX_W'(i);
            end
            // Survivors form an oldest prefix, so counting them gives the truncated occupancy.
            if (w_valid[i] && !(f_age(r_rob[i]) > w_flush_age)) w_keep = w_keep + OCC_W'(1);
        end
        for (int unsigned i = 0; i < N_ENTRIES; i++) begin
            w_shift[i] = w_deq && (IDX_W'(i) >= w_sel) && (i < N_ENTRIES - 1);
        end
    end

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            r_occ <= '0;
            for (int unsigned i = 0; i < N_ENTRIES; i++) begin
                r_rob[i] <= '0;
                r_sv[i]  <= '0;
                r_sr[i]  <= '0;
                r_pay[i] <= '0;
                for (int unsigned s = 0; s < 2; s++) begin
                    r_stag[i][s]  <= '0;
                    r_sdata[i][s] <= '0;
                end
            end
        end else begin
            r_occ <= flush_valid ? w_keep : r_occ + OCC_W'(w_enq) - OCC_W'(w_deq);
            for (int unsigned i = 0; i < N_ENTRIES; i++) begin
                // Modulo keeps the unused upper index in range; w_shift is never set for the top slot.
                if (w_shift[i]) begin
                    r_rob[i] <= r_rob[(i + 1) % N_ENTRIES];
                    r_sv[i]  <= r_sv[(i + 1) % N_ENTRIES];
                    r_sr[i]  <= w_sr_eff[(i + 1) % N_ENTRIES];
                    r_pay[i] <= r_pay[(i + 1) % N_ENTRIES];
                    for (int unsigned s = 0; s < 2; s++) begin
                        r_stag[i][s]  <= r_stag[(i + 1) % N_ENTRIES][s];
                        r_sdata[i][s] <= w_sd_eff[(i + 1) % N_ENTRIES][s];
                    end
                end else begin
                    r_sr[i] <= w_sr_eff[i];
                    for (int unsigned s = 0; s < 2; s++) r_sdata[i][s] <= w_sd_eff[i][s];
                end
                if (w_enq && OCC_W'(i) == w_enq_slot) begin
                    r_rob[i] <= enq_rob_id;
                    r_sv[i]  <= enq_src_valid;
                    r_sr[i]  <= w_esr;
                    r_pay[i] <= enq_payload;
                    for (int unsigned s = 0; s < 2; s++) begin
                        r_stag[i][s]  <= enq_src_rob_id[s*RIW +: RIW];
                        r_sdata[i][s] <= w_esd[s];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            r_iss_valid <= 1'b0;
            r_iss_rob   <= '0;
            r_iss_data  <= '0;
            r_iss_pay   <= '0;
        end else if (flush_valid) begin
            if (w_load || f_age(r_iss_rob) > w_flush_age) r_iss_valid <= 1'b0;
        end else if (w_load) begin
            r_iss_valid <= w_any;
            if (w_any) begin
                r_iss_rob  <= r_rob[w_sel];
                r_iss_data <= {w_sd_eff[w_sel][1], w_sd_eff[w_sel][0]};
                r_iss_pay  <= r_pay[w_sel];
            end
        end
    end

    assign issue_valid    = r_iss_valid;
    assign issue_rob_id   = r_iss_rob;
    assign issue_src_data = r_iss_data;
    assign issue_payload  = r_iss_pay;
    assign occupancy      = r_occ;

    a_single_match: assert property (@(posedge clk) disable iff (!rst_aL) !w_multi)
        else $error("several broadcast channels matched one source");

endmodule
